// File: rtl/ctrl_pkg.sv
// Shared definitions for the processor control unit: opcodes, FSM states and IR field positions.
package ctrl_pkg;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_MVNZ = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned X_MSB  = 11;
  localparam int unsigned X_LSB  = 9;
  localparam int unsigned Y_MSB  = 8;
  localparam int unsigned Y_LSB  = 6;

  typedef enum logic [2:0] {
    T0,
    T1,
    T2,
    T3,
    HALT
  } state_e;

endpackage

// File: rtl/dec3to8.sv
// 3-bit to one-hot 8-bit decoder with enable; output is all zeros when disabled.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Multicycle control unit sequencing T0-T3 for the 16-bit simple processor.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes set a sticky Illegal flag and halt the FSM.
module proc_control_fsm #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned IRW   = 16,
  parameter int unsigned OPW   = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [IRW-1:0]   IR,
  input  logic             GNZ,
  output logic             IRin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             Gout,
  output logic             DINout,
  output logic             Ain,
  output logic             Gin,
  output logic [OPW-1:0]   AluOp,
  output logic             Done,
  output logic             Illegal
);
  import ctrl_pkg::*;

  state_e state_q, state_d;

  logic [3:0] opcode;
  logic [2:0] x_fld, y_fld;
  logic       unused_ir;

  assign opcode    = IR[OP_MSB:OP_LSB];
  assign x_fld     = IR[X_MSB:X_LSB];
  assign y_fld     = IR[Y_MSB:Y_LSB];
  assign unused_ir = ^IR[Y_LSB-1:0];

  logic           irin, rin_en, rout_en, gout, dinout, ain, gin, done, illegal_hit;
  logic [2:0]     rout_sel;
  logic [OPW-1:0] aluop;
  logic [7:0]     rin_full, rout_full;

  always_comb begin
    state_d     = state_q;
    irin        = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel    = y_fld;
    gout        = 1'b0;
    dinout      = 1'b0;
    ain         = 1'b0;
    gin         = 1'b0;
    aluop       = '0;
    done        = 1'b0;
    illegal_hit = 1'b0;
    unique case (state_q)
      T0: begin
        irin = Run;
        if (Run) state_d = T1;
      end
      T1: begin
        state_d = T0;
        case (opcode)
          OP_MV: begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            done    = 1'b1;
          end
          OP_MVI: begin
            dinout = 1'b1;
            rin_en = 1'b1;
            done   = 1'b1;
          end
          OP_MVNZ: begin
            rout_en = GNZ;
            rin_en  = GNZ;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: begin
            rout_sel = x_fld;
            rout_en  = 1'b1;
            ain      = 1'b1;
            state_d  = T2;
          end
          default: begin
            illegal_hit = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = HALT;
`else
            done = 1'b1;
`endif
          end
        endcase
      end
      T2: begin
        rout_en = 1'b1;
        gin     = 1'b1;
        aluop   = opcode;
        state_d = T3;
      end
      T3: begin
        gout    = 1'b1;
        rin_en  = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      HALT: state_d = HALT;
`else
      HALT: state_d = T0;
`endif
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= T0;
    else         state_q <= state_d;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | illegal_hit;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) illegal_q <= 1'b0;
    else         illegal_q <= illegal_d;
  end

  assign Illegal = illegal_q;
`else
  logic unused_illegal_hit;
  assign unused_illegal_hit = illegal_hit;
  assign Illegal            = 1'b0;
`endif

  dec3to8 u_dec_rin (
    .en_i     (rin_en),
    .sel_i    (x_fld),
    .onehot_o (rin_full)
  );

  dec3to8 u_dec_rout (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (rout_full)
  );

  // Outputs are masked while Resetn is low so a held Run cannot raise IRin during reset.
  assign IRin   = irin & Resetn;
  assign Rin    = rin_full[NREGS-1:0] & {NREGS{Resetn}};
  assign Rout   = rout_full[NREGS-1:0] & {NREGS{Resetn}};
  assign Gout   = gout & Resetn;
  assign DINout = dinout & Resetn;
  assign Ain    = ain & Resetn;
  assign Gin    = gin & Resetn;
  assign AluOp  = aluop & {OPW{Resetn}};
  assign Done   = done & Resetn;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed self-checking bench for proc_control_fsm (default and CTRL_ILLEGAL_TRAP_EN builds).
module tb_proc_control_fsm;

  logic        Clock, Resetn, Run, GNZ;
  logic [15:0] IR;
  logic        IRin, Gout, DINout, Ain, Gin, Done, Illegal;
  logic [7:0]  Rin, Rout;
  logic [3:0]  AluOp;

  int checks = 0;
  int errors = 0;
  logic [25:0] e;

  proc_control_fsm #(.NREGS(8), .IRW(16), .OPW(4)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .IR      (IR),
    .GNZ     (GNZ),
    .IRin    (IRin),
    .Rin     (Rin),
    .Rout    (Rout),
    .Gout    (Gout),
    .DINout  (DINout),
    .Ain     (Ain),
    .Gin     (Gin),
    .AluOp   (AluOp),
    .Done    (Done),
    .Illegal (Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [25:0] outs();
    return {IRin, Rin, Rout, Gout, DINout, Ain, Gin, AluOp, Done};
  endfunction

  function automatic logic [25:0] pk(input logic irin, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic gout, input logic din,
                                     input logic ain, input logic gin, input logic [3:0] op,
                                     input logic done);
    return {irin, rin, rout, gout, din, ain, gin, op, done};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Run = 1'b1; IR = 16'h0000; GNZ = 1'b0;
    #3;
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_outs got %h exp %h", outs(), e); end
    checks++;
    if (Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", Illegal); end
    tick();
    #1 Resetn = 1'b1;
    #1;
    e = pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_first_t0 got %h exp %h", outs(), e); end
    tick();
    Run = 1'b0;
    #1;
    e = pk(0, 8'h01, 8'h01, 0, 0, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_reach_t1 got %h exp %h", outs(), e); end
    tick();
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_back_t0 got %h exp %h", outs(), e); end
  endtask

  task automatic test_mv();
    IR = 16'h0A40; Run = 1'b1;
    #1;
    tick();
    Run = 1'b0;
    #1;
    e = pk(0, 8'h20, 8'h02, 0, 0, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL mv_t1 got %h exp %h", outs(), e); end
    tick();
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL mv_t0 got %h exp %h", outs(), e); end
  endtask

  task automatic test_mvi();
    IR = 16'h1C00; Run = 1'b1;
    tick();
    Run = 1'b0;
    #1;
    e = pk(0, 8'h40, 8'h00, 0, 1, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL mvi_t1 got %h exp %h", outs(), e); end
    tick();
  endtask

  task automatic test_mvnz();
    IR = 16'h4600; GNZ = 1'b0; Run = 1'b1;
    tick();
    Run = 1'b0;
    #1;
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL mvnz_gnz0 got %h exp %h", outs(), e); end
    tick();
    GNZ = 1'b1; Run = 1'b1;
    tick();
    Run = 1'b0;
    #1;
    e = pk(0, 8'h08, 8'h01, 0, 0, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL mvnz_gnz1 got %h exp %h", outs(), e); end
    tick();
    GNZ = 1'b0;
  endtask

  task automatic test_add();
    IR = 16'h5280; Run = 1'b1;
    tick();
    Run = 1'b0;
    #1;
    e = pk(0, 8'h00, 8'h02, 0, 0, 1, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL add_t1 got %h exp %h", outs(), e); end
    tick();
    e = pk(0, 8'h00, 8'h04, 0, 0, 0, 1, 4'h5, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL add_t2 got %h exp %h", outs(), e); end
    tick();
    e = pk(0, 8'h02, 8'h00, 1, 0, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL add_t3 got %h exp %h", outs(), e); end
    tick();
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL add_done_t0 got %h exp %h", outs(), e); end
  endtask

  task automatic test_alu_ops();
    logic [3:0] ops [4] = '{4'h7, 4'h8, 4'h9, 4'hA};
    for (int i = 0; i < 4; i++) begin
      IR = {ops[i], 3'd7, 3'd3, 6'd0}; Run = 1'b1;
      tick();
      Run = 1'b0;
      #1;
      e = pk(0, 8'h00, 8'h80, 0, 0, 1, 0, 4'h0, 0);
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL alu_t1 op %h got %h exp %h", ops[i], outs(), e); end
      tick();
      e = pk(0, 8'h00, 8'h08, 0, 0, 0, 1, ops[i], 0);
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL alu_t2 op %h got %h exp %h", ops[i], outs(), e); end
      tick();
      e = pk(0, 8'h80, 8'h00, 1, 0, 0, 0, 4'h0, 1);
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL alu_t3 op %h got %h exp %h", ops[i], outs(), e); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    IR = 16'h1C00; Run = 1'b1;
    tick();
    e = pk(0, 8'h40, 8'h00, 0, 1, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL b2b_first got %h exp %h", outs(), e); end
    tick();
    IR = 16'h0A40;
    #1;
    e = pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL b2b_t0 got %h exp %h", outs(), e); end
    tick();
    Run = 1'b0;
    #1;
    e = pk(0, 8'h20, 8'h02, 0, 0, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL b2b_second got %h exp %h", outs(), e); end
    tick();
  endtask

  task automatic test_reset_mid();
    IR = 16'h6040; Run = 1'b1;
    tick();
    Run = 1'b0;
    tick();
    #1;
    e = pk(0, 8'h00, 8'h02, 0, 0, 0, 1, 4'h6, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL sub_t2 got %h exp %h", outs(), e); end
    Resetn = 1'b0;
    #1;
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL midreset_drop got %h exp %h", outs(), e); end
    #2 Resetn = 1'b1;
    tick();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL midreset_t0a got %h exp %h", outs(), e); end
    tick();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL midreset_t0b got %h exp %h", outs(), e); end
  endtask

  task automatic test_illegal();
    IR = 16'hF000; Run = 1'b1;
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL trap_t1 got %h exp %h", outs(), e); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL trap_halt%0d got %h exp %h", i, outs(), e); end
      checks++;
      if (Illegal !== 1'b1) begin errors++; $display("FAIL trap_sticky%0d got %b exp 1", i, Illegal); end
    end
    Resetn = 1'b0;
    #1;
    checks++;
    if (Illegal !== 1'b0) begin errors++; $display("FAIL trap_clear got %b exp 0", Illegal); end
    #1 Resetn = 1'b1;
    Run = 1'b0;
    tick();
`else
    Run = 1'b0;
    #1;
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 1);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL illegal_f_t1 got %h exp %h", outs(), e); end
    tick();
    IR = 16'h2000; Run = 1'b1;
    tick();
    Run = 1'b0;
    #1;
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL illegal_2_t1 got %h exp %h", outs(), e); end
    tick();
    e = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL illegal_t0 got %h exp %h", outs(), e); end
    checks++;
    if (Illegal !== 1'b0) begin errors++; $display("FAIL illegal_flag got %b exp 0", Illegal); end
`endif
  endtask

  initial begin
    test_reset();
    test_mv();
    test_mvi();
    test_mvnz();
    test_add();
    test_alu_ops();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
Multicycle control unit for the 16-bit simple processor. It decodes the instruction register and sequences the register file, A register, ALU, G register and the shared bus mux over time steps T0–T3. It drives the ALU 4-bit operation select and raises Done when each instruction retires.

Parameters:
NREGS, 8, number of general registers; width of the Rin/Rout one-hot buses (X/Y fields are 3 bits, so the maximum is 8)
IRW, 16, instruction width
OPW, 4, opcode width; also the ALU select width

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
Run  in  1  start request; sampled only in T0
IR  in  IRW  instruction register contents (external register, loaded via IRin): opcode IR[15:12], X IR[11:9], Y IR[8:6]; IR[5:0] ignored
GNZ  in  1  G register non-zero flag, used by mvnz
IRin  out  1  load enable for IR
Rin  out  NREGS  one-hot register write enables
Rout  out  NREGS  one-hot register-to-bus enables
Gout  out  1  G drives bus
DINout  out  1  DIN drives bus
Ain  out  1  load A from bus
Gin  out  1  load G from ALU
AluOp  out  OPW  ALU select
Done  out  1  instruction complete (one cycle)
Illegal  out  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain. Resetn is asynchronous and active-low.
- Reset: state=T0; Illegal=0. All other outputs are combinational functions of state, IR, GNZ and Run, so they read 0 in T0 while Run=0.
- Reset mid-instruction: abort to T0 immediately. No further enables are issued.
- Opcodes: 0000 mv, 0001 mvi, 0100 mvnz, 0101 add, 0110 sub, 0111 or, 1000 slt, 1001 sll, 1010 srl. All others are illegal (0010, 0011, 1011–1111).
- T0: IRin=Run. If Run=1, next state is T1; otherwise stay in T0.
- T1:
  - mv: Rout[Y]=1, Rin[X]=1, Done=1; next T0.
  - mvi: DINout=1, Rin[X]=1, Done=1; next T0.
  - mvnz: if GNZ=1, Rout[Y]=1 and Rin[X]=1; Done=1 regardless; next T0.
  - ALU ops: Rout[X]=1, Ain=1; next T2.
  - illegal: Done=1, no enables; next T0.
- T2 (ALU ops only): Rout[Y]=1, Gin=1, AluOp=IR[15:12]; next T3.
- T3 (ALU ops only): Gout=1, Rin[X]=1, Done=1; next T0.
- AluOp is 0000 outside T2.
- Bus source invariant: at most one of {any Rout bit, Gout, DINout} is asserted in any cycle. Rin and Rout are each at most one-hot.
- Latency, Run→Done: mv/mvi/mvnz/illegal take 2 cycles; ALU ops take 4 cycles.
- Back-to-back: the instruction after Done starts when Run=1 in the following T0 cycle.
- Run deasserted after T0 is ignored; the instruction completes.
- X==Y is legal; the enables are generated as specified.
- IR must be stable from T1 through T3; the controller does not latch it.

Optional Feature:
Macro: CTRL_ILLEGAL_TRAP_EN
- Defined:
  - An illegal opcode decoded in T1 sets Illegal=1. It stays set until Resetn.
  - The FSM enters a HALT state: no enables, Done=0, Run ignored, exit only by reset.
  - Done is not raised for the trapping instruction.
- Undefined:
  - Illegal is tied to 0 and there is no HALT state.
  - An illegal opcode behaves as a one-step no-op with Done.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_MV … OP_SRL), shared with the ALU;
  - the state enum T0/T1/T2/T3/HALT;
  - IR field positions.
- One sub-module: dec3to8, a 3-bit to one-hot 8-bit decoder with enable. Two instances generate Rin and Rout from X and Y.

Test Plan:
- Reset with Run=1 held, then release Resetn: all outputs 0 in the reset cycle; IRin=1 in the first T0; FSM reaches T1.
- IR=0x0A40 (mv R5,R1): T1 shows Rout=0000_0010, Rin=0010_0000, Done=1; next cycle is T0.
- IR=0x5280 (add R1,R2): T1 Rout=0000_0010, Ain=1; T2 Rout=0000_0100, Gin=1, AluOp=0101; T3 Gout=1, Rin=0000_0010, Done=1.
- IR=0x4600 (mvnz R3,R0):
  - GNZ=0 → T1 has Done=1, Rin=0.
  - GNZ=1 → Rout=0000_0001, Rin=0000_1000.
- Assert Resetn=0 asynchronously in T2 of a sub: outputs drop to 0 immediately; FSM restarts in T0 with no Gout/Rin pulse.
- IR=0xF000:
  - Macro off: Done in T1, no enables.
  - Macro on: Illegal=1 and sticky, Done=0, and Run pulses give no IRin until reset.
